// File: rtl/bitfusion_pkg.sv
// Shared definitions for the BitFusion column feeder: default geometry,
// FSM state encoding and the flush-length helper.
package bitfusion_pkg;

  localparam int DEF_LANES       = 16;
  localparam int DEF_W           = 32;
  localparam int DEF_OUT_W       = 28;
  localparam int DEF_WEIGHT_LEAD = 2;
  localparam int DEF_ACC_LAT     = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_DONE   = 2'd3
  } feeder_state_e;

  // Cycles spent in FLUSH so that DONE lands exactly when the column's
  // total for the last beat is valid (last accept + lanes + lead + acc_lat).
  function automatic int flush_load(input int lanes, input int lead, input int acc_lat);
    return lanes + lead + acc_lat - 1;
  endfunction

endpackage

// File: rtl/lane_delay.sv
// Zero-reset shift register used to skew one column lane.
// DEPTH = 0 degenerates to a wire.
module lane_delay
  import bitfusion_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  if (DEPTH == 0) begin : g_pass
    // No register stage: clock and reset are intentionally not used here.
    logic unused_ok;
    assign unused_ok = &{1'b0, clk_i, rst_ni};
    assign q_o = d_i;
  end else begin : g_shift
    logic [W-1:0] stage_q [DEPTH];

    // Shift the lane word one stage per cycle; reset clears every stage so
    // the column only ever sees zeros after an abort.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
      end else begin
        stage_q[0] <= d_i;
        for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign q_o = stage_q[DEPTH-1];
  end

endmodule

// File: rtl/bitfusion_column_feeder.sv
// Source-side feeder for a BitFusion column: accepts one activation/weight
// beat per cycle, skews lanes to match the column's PE register chain,
// flushes with zeros after the programmed beat count and captures the
// column total as the job result.
module bitfusion_column_feeder
  import bitfusion_pkg::*;
#(
  parameter int LANES       = DEF_LANES,
  parameter int W           = DEF_W,
  parameter int WEIGHT_LEAD = DEF_WEIGHT_LEAD,
  parameter int ACC_LAT     = DEF_ACC_LAT,
  parameter int OUT_W       = DEF_OUT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [15:0]        num_beats,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [LANES*W-1:0] in_data,
  input  logic [LANES*W-1:0] w_data,
  output logic [LANES*W-1:0] col_input,
  output logic [LANES*W-1:0] col_weight,
  input  logic [OUT_W-1:0]   col_total,
  output logic               busy,
  output logic               result_valid,
  output logic [OUT_W-1:0]   result
);

  localparam logic [15:0] FLUSH_LOAD = 16'(flush_load(LANES, WEIGHT_LEAD, ACC_LAT));

  feeder_state_e      state_q;
  logic [15:0]        beats_left_q;
  logic [15:0]        flush_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               result_valid_q;
  logic [OUT_W-1:0]   result_q;

  logic               handshake;
  logic [LANES*W-1:0] inj_in;
  logic [LANES*W-1:0] inj_w;

  // A cycle without a handshake injects an all-zero beat, which contributes
  // nothing to the column sum; this also zeroes the lanes during FLUSH.
  assign handshake = in_valid & in_ready_q;
  assign inj_in    = handshake ? in_data : '0;
  assign inj_w     = handshake ? w_data  : '0;

  // Job control: sequence IDLE -> STREAM -> FLUSH -> DONE with registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      beats_left_q   <= '0;
      flush_q        <= '0;
      in_ready_q     <= 1'b0;
      busy_q         <= 1'b0;
      result_valid_q <= 1'b0;
      result_q       <= '0;
    end else begin
      result_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          // A zero-length job is not a job: stay idle.
          if (start && (num_beats != 16'd0)) begin
            beats_left_q <= num_beats;
            state_q      <= ST_STREAM;
            in_ready_q   <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        ST_STREAM: begin
          if (handshake) begin
            if (beats_left_q == 16'd1) begin
              beats_left_q <= '0;
              flush_q      <= FLUSH_LOAD;
              state_q      <= ST_FLUSH;
              in_ready_q   <= 1'b0;
            end else begin
              beats_left_q <= beats_left_q - 16'd1;
            end
          end
        end
        ST_FLUSH: begin
          // The counter reaching zero coincides with entering DONE, so the
          // result pulse lands on the cycle the column total becomes valid.
          if (flush_q <= 16'd1) begin
            flush_q        <= '0;
            state_q        <= ST_DONE;
            result_valid_q <= 1'b1;
          end else begin
            flush_q <= flush_q - 16'd1;
          end
        end
        ST_DONE: begin
          result_q <= col_total;
          state_q  <= ST_IDLE;
          busy_q   <= 1'b0;
        end
        default: begin
          state_q    <= ST_IDLE;
          in_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign busy         = busy_q;
  assign result_valid = result_valid_q;
  // During the DONE cycle the live column total is presented alongside the
  // pulse; afterwards the captured copy is held until the next job.
  assign result       = result_valid_q ? col_total : result_q;

  // Lane k weight is delayed k cycles; lane k input trails by the extra
  // weight-path depth so both operands meet in the same PE cycle.
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    lane_delay #(
      .W     (W),
      .DEPTH (k)
    ) u_wdly (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (inj_w[k*W +: W]),
      .q_o    (col_weight[k*W +: W])
    );

    lane_delay #(
      .W     (W),
      .DEPTH (k + WEIGHT_LEAD)
    ) u_idly (
      .clk_i  (clk),
      .rst_ni (reset),
      .d_i    (inj_in[k*W +: W]),
      .q_o    (col_input[k*W +: W])
    );
  end

endmodule

// File: tb/tb_bitfusion_column_feeder.sv
// Self-checking bench for bitfusion_column_feeder: randomized jobs checked
// every cycle against a history-based reference model.
module tb_bitfusion_column_feeder;

  localparam int LANES   = 16;
  localparam int W       = 32;
  localparam int WL      = 2;
  localparam int ACC_LAT = 1;
  localparam int OUT_W   = 28;
  localparam int CW      = LANES * W;
  localparam int LAT     = LANES + WL + ACC_LAT;
  localparam int HN      = 4096;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [15:0]      num_beats = '0;
  logic             in_valid = 1'b0;
  logic [CW-1:0]    in_data = '0;
  logic [CW-1:0]    w_data = '0;
  logic [OUT_W-1:0] col_total = '0;
  logic             in_ready;
  logic             busy;
  logic             result_valid;
  logic [CW-1:0]    col_input;
  logic [CW-1:0]    col_weight;
  logic [OUT_W-1:0] result;

  bitfusion_column_feeder dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .num_beats    (num_beats),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .w_data       (w_data),
    .col_input    (col_input),
    .col_weight   (col_weight),
    .col_total    (col_total),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model: job bookkeeping plus a per-cycle history of injected beats.
  int               cyc = 0;
  int               epoch = 0;
  logic [CW-1:0]    hin [HN];
  logic [CW-1:0]    hw  [HN];
  bit               m_busy = 1'b0;
  bit               m_rdy = 1'b0;
  int               m_left = 0;
  int               m_due = -1;
  int               n_acc = 0;
  int               last_acc = -1;
  logic [OUT_W-1:0] m_result = '0;
  int               dut_hs = 0;
  int               rv_count = 0;
  int               rv_cyc = -1;

  logic [CW-1:0]    ew, ei, tmp;
  logic             acc;
  logic [OUT_W-1:0] er;

  always @(posedge clk) begin
    if (reset === 1'b1) begin
      if (!m_busy) begin
        if (start && num_beats != 16'd0) begin
          m_busy = 1'b1;
          m_rdy  = 1'b1;
          m_left = int'(num_beats);
        end
      end else if (m_rdy) begin
        if (in_valid) begin
          m_left--;
          n_acc++;
          last_acc = cyc;
          if (m_left == 0) begin
            m_rdy = 1'b0;
            m_due = cyc + LAT;
          end
        end
      end else if (cyc == m_due) begin
        m_result = col_total;
        m_busy   = 1'b0;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    acc = (reset === 1'b1) && m_rdy && in_valid;
    hin[cyc % HN] = acc ? in_data : '0;
    hw[cyc % HN]  = acc ? w_data  : '0;
    ew = '0;
    ei = '0;
    for (int k = 0; k < LANES; k++) begin
      if (cyc - k >= epoch) begin
        tmp = hw[(cyc - k) % HN];
        ew[k*W +: W] = tmp[k*W +: W];
      end
      if (cyc - k - WL >= epoch) begin
        tmp = hin[(cyc - k - WL) % HN];
        ei[k*W +: W] = tmp[k*W +: W];
      end
    end
    er = (cyc == m_due) ? col_total : m_result;
    chk("col_weight", col_weight, ew);
    chk("col_input", col_input, ei);
    chk("in_ready", CW'(in_ready), CW'(m_rdy));
    chk("busy", CW'(busy), CW'(m_busy));
    chk("result_valid", CW'(result_valid), CW'(cyc == m_due));
    chk("result", CW'(result), CW'(er));
    if (in_valid && in_ready) dut_hs++;
    if (result_valid) begin
      rv_count++;
      rv_cyc = cyc;
    end
  end

  function automatic logic [CW-1:0] rnd_bus();
    logic [CW-1:0] v;
    for (int k = 0; k < LANES; k++) v[k*W +: W] = $urandom | 32'h1;
    return v;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      col_total = OUT_W'($urandom);
    end
  end

  task automatic run_job(input int nb, input int bub_pct, input int bubble_at,
                         input bit pat, input bit poke_start);
    int acc0, hs0, rv0, g, scyc;
    acc0 = n_acc;
    hs0  = dut_hs;
    rv0  = rv_count;
    @(posedge clk); #1;
    start     = 1'b1;
    num_beats = 16'(nb);
    in_valid  = 1'b0;
    scyc = 0;
    g    = 0;
    while ((n_acc - acc0 < nb) && (g < 4 * nb + 50)) begin
      @(posedge clk); #1;
      g++;
      start     = poke_start && (scyc == 1);
      num_beats = 16'($urandom_range(1, 20));
      in_valid  = (scyc == bubble_at) ? 1'b0 : ($urandom_range(0, 99) >= bub_pct);
      if (pat) begin
        for (int k = 0; k < LANES; k++) begin
          in_data[k*W +: W] = 32'(k + 1);
          w_data[k*W +: W]  = 32'd1;
        end
      end else begin
        in_data = rnd_bus();
        w_data  = rnd_bus();
      end
      scyc++;
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("handshakes", CW'(dut_hs - hs0), CW'(nb));
    g = 0;
    while ((rv_count == rv0) && (g < LAT + 10)) begin
      @(negedge clk); #1;
      g++;
    end
    chk("rv_count", CW'(rv_count - rv0), CW'(1));
    chk("rv_latency", CW'(rv_cyc - last_acc), CW'(LAT));
  endtask

  initial begin
    int rv0;
    for (int i = 0; i < HN; i++) begin
      hin[i] = '0;
      hw[i]  = '0;
    end
    #1 reset = 1'b0;
    #1;
    chk("rst_in_ready", CW'(in_ready), CW'(0));
    chk("rst_busy", CW'(busy), CW'(0));
    chk("rst_result_valid", CW'(result_valid), CW'(0));
    chk("rst_result", CW'(result), CW'(0));
    chk("rst_col_input", col_input, CW'(0));
    chk("rst_col_weight", col_weight, CW'(0));
    #15 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Single beat with lane pattern (activation k+1, weight 1).
    run_job(1, 0, -1, 1'b1, 1'b0);
    // Four beats with a bubble on the second STREAM cycle.
    run_job(4, 0, 1, 1'b0, 1'b0);

    // Zero-length start is ignored.
    rv0 = rv_count;
    @(posedge clk); #1;
    start     = 1'b1;
    num_beats = 16'd0;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("nb0_busy", CW'(busy), CW'(0));
    chk("nb0_no_rv", CW'(rv_count - rv0), CW'(0));

    // Start pulsed during STREAM must not disturb the running job.
    run_job(6, 20, -1, 1'b0, 1'b1);

    // Reset mid-STREAM with non-zero data in flight.
    @(posedge clk); #1;
    start     = 1'b1;
    num_beats = 16'd10;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) begin
      in_valid = 1'b1;
      in_data  = rnd_bus();
      w_data   = rnd_bus();
      @(posedge clk); #1;
    end
    #1;
    reset    = 1'b0;
    m_busy   = 1'b0;
    m_rdy    = 1'b0;
    m_left   = 0;
    m_due    = -1;
    m_result = '0;
    epoch    = cyc;
    #1;
    chk("abort_col_input", col_input, CW'(0));
    chk("abort_col_weight", col_weight, CW'(0));
    chk("abort_busy", CW'(busy), CW'(0));
    chk("abort_in_ready", CW'(in_ready), CW'(0));
    chk("abort_result_valid", CW'(result_valid), CW'(0));
    in_valid = 1'b0;
    rv0 = rv_count;
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    repeat (LAT + 5) begin
      @(posedge clk); #1;
    end
    chk("abort_no_rv", CW'(rv_count - rv0), CW'(0));
    run_job(3, 0, -1, 1'b0, 1'b0);

    // Back-to-back jobs: second start in the cycle after result_valid.
    run_job(5, 0, -1, 1'b0, 1'b0);
    run_job(2, 0, -1, 1'b0, 1'b0);

    // Randomized jobs.
    for (int j = 0; j < 20; j++) begin
      run_job($urandom_range(1, 12), 30, -1, 1'b0, 1'($urandom_range(0, 1)));
    end

    repeat (3) begin
      @(posedge clk); #1;
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bitfusion_column_feeder.md
# bitfusion_column_feeder

Source-side companion of the BitFusion column: accepts one activation/weight beat per cycle over a valid/ready stream and drives the column's 16 input lanes and 16 weight-buffer lanes. Lane k is delayed by k cycles to match the column's per-PE register chain, and the weight lanes are issued ahead of the input lanes by the weight path's register depth. After a programmed number of beats it flushes the pipeline with zeros, captures the column's `total_output`, and reports one result per job.

## Interface
Parameters:
- LANES, 16, PEs per column
- W, 32, bits per lane word
- WEIGHT_LEAD, 2, cycles the weight path (WBUF + weight mux register) lags the input path
- ACC_LAT, 1, cycles from the last PE register to a valid `total_output`
- OUT_W, 28, column result width

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  job start pulse, sampled in IDLE only
- num_beats  in  16  beats in the job, sampled with start
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- in_data  in  LANES*W  activations, lane k at [k*W +: W]
- w_data  in  LANES*W  weights, same packing
- col_input  out  LANES*W  to sorted_input_1..16 (lane 0 = _1)
- col_weight  out  LANES*W  to WBUF_data_in_1..16
- col_total  in  OUT_W  column total_output
- busy  out  1  high outside IDLE
- result_valid  out  1  one-cycle pulse
- result  out  OUT_W  captured col_total, held until next capture

## Operation
- FSM states: IDLE, STREAM, FLUSH, DONE.
- IDLE: start & num_beats≠0 → latch beats_left=num_beats, go to STREAM. start with num_beats=0 is ignored.
- STREAM: in_ready=1. An accepted beat decrements beats_left. A cycle with no handshake injects an all-zero beat; a zero product adds nothing to the sum. The accept of the last beat → FLUSH, flush counter = LANES+WEIGHT_LEAD+ACC_LAT−1.
- FLUSH: in_ready=0; inject zeros; count down. Count 0 → DONE.
- DONE: result←col_total, result_valid=1 for this cycle → IDLE.
- start outside IDLE is ignored.
- Skew:
  - Weight lane k = w_data of the injected beat delayed k cycles.
  - Input lane k = in_data delayed k+WEIGHT_LEAD cycles.
  - Lane-0 weight is combinational from the injected beat (delay 0). All other lanes come from per-lane zero-initialised shift registers.
- The injected beat is the input word on a handshake cycle and zero otherwise.

## Timing
- Reset values: in_ready=0, busy=0, result_valid=0, result=0, col_input=0, col_weight=0, all delay stages 0, FSM=IDLE, counters 0.
- start→first in_ready: 1 cycle.
- Last-beat handshake at cycle t → result_valid at t+LANES+WEIGHT_LEAD+ACC_LAT (t+19 with defaults).
- Throughput: one beat per cycle. No back-to-back overlap between jobs; the next start is accepted from the IDLE cycle after DONE.
- Reset asserted mid-job: immediate return to IDLE. Delay lines clear, so the column sees zeros. No result_valid for the aborted job.
- Simultaneous start and reset: reset wins.

## Structure
- Shared package `bitfusion_pkg`: LANES, W, OUT_W, WEIGHT_LEAD defaults, and the FSM state enum.
- Sub-module `lane_delay #(W, DEPTH)`: zero-reset shift register, DEPTH≥0 (DEPTH=0 is a pass-through). Instantiated 2×LANES via generate.
- Top level: FSM, beats_left and flush counters, beat injection mux, result register.

## Test plan
- Single beat, num_beats=1, lane k activation=k+1 and weight=1:
  - Weight lane k shows 1 exactly k cycles after accept.
  - Input lane k shows k+1 exactly k+2 cycles after accept.
  - result_valid exactly 19 cycles after accept; result equals col_total at that cycle.
- num_beats=4 with in_valid deasserted on the 2nd cycle of STREAM:
  - Zero beat injected on the bubble cycle.
  - 4 handshakes total.
  - in_ready drops the cycle after the 4th accept.
- start with num_beats=0 → no busy, no in_ready, no result_valid.
- start pulsed during STREAM → ignored; beats_left and the result cycle are unchanged.
- reset deasserted→asserted low mid-STREAM with non-zero data in flight:
  - All col_input/col_weight lanes are 0 immediately.
  - busy=0, no result_valid.
  - A new job then completes normally.
- Two consecutive jobs: the second start is given in the cycle after result_valid → second result_valid 19 cycles after its last accept; the first result is held until then.
